// File: rtl/egress_ptr_queue_if.sv
// Handshake and status bundle between the forwarding translator, the per-port
// descriptor queues and the egress readers.
interface egress_ptr_queue_if #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned DROP_CNT_W  = 16
);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [NUM_PORTS-1:0]                 write_reqs_i;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]     start_ptrs_i;
  logic [NUM_PORTS-1:0]                 flush_i;
  logic [NUM_PORTS-1:0]                 deq_ready_i;
  logic [NUM_PORTS-1:0]                 deq_valid_o;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]     deq_ptr_o;
  logic [NUM_PORTS-1:0]                 full_o;
  logic [NUM_PORTS-1:0][CNT_W-1:0]      count_o;
  logic [NUM_PORTS-1:0]                 drop_o;
  logic [NUM_PORTS-1:0][DROP_CNT_W-1:0] drop_count_o;

  // Queue side
  modport slave (
    input  write_reqs_i, start_ptrs_i, flush_i, deq_ready_i,
    output deq_valid_o, deq_ptr_o, full_o, count_o, drop_o, drop_count_o
  );

  // Translator / reader side
  modport master (
    output write_reqs_i, start_ptrs_i, flush_i, deq_ready_i,
    input  deq_valid_o, deq_ptr_o, full_o, count_o, drop_o, drop_count_o
  );
endinterface

// File: rtl/egress_ptr_queue.sv
// Per-egress-port FIFOs of frame start pointers. First-word-fall-through from
// registered storage, saturating per-port drop counters, synchronous flush.
module egress_ptr_queue #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned DROP_CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  egress_ptr_queue_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] PtrLast  = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0] CntFull  = CNT_W'(QUEUE_DEPTH);

  logic [ADDR_W-1:0] mem_q [NUM_PORTS][QUEUE_DEPTH];

  logic [NUM_PORTS-1:0][PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [NUM_PORTS-1:0][PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [NUM_PORTS-1:0][CNT_W-1:0]      count_q, count_d;
  logic [NUM_PORTS-1:0][DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [NUM_PORTS-1:0]                 drop_q, drop_d;

  logic [NUM_PORTS-1:0] deq_hs;
  logic [NUM_PORTS-1:0] is_full;
  logic [NUM_PORTS-1:0] enq_acc;

  // Next-state for pointers, occupancy and drop accounting, port by port
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    drop_d     = '0;
    deq_hs     = '0;
    is_full    = '0;
    enq_acc    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      is_full[p] = (count_q[p] == CntFull);
      deq_hs[p]  = (count_q[p] != '0) && bus.deq_ready_i[p];
      if (bus.flush_i[p]) begin
        // Flush wins over any same-cycle traffic; a discarded write is not a drop
        rd_ptr_d[p] = '0;
        wr_ptr_d[p] = '0;
        count_d[p]  = '0;
      end else begin
        // A full queue still accepts when its head leaves in the same cycle
        enq_acc[p] = bus.write_reqs_i[p] && (!is_full[p] || deq_hs[p]);
        drop_d[p]  = bus.write_reqs_i[p] && is_full[p] && !deq_hs[p];
        if (deq_hs[p]) begin
          rd_ptr_d[p] = (rd_ptr_q[p] == PtrLast) ? '0 : rd_ptr_q[p] + 1'b1;
        end
        if (enq_acc[p]) begin
          wr_ptr_d[p] = (wr_ptr_q[p] == PtrLast) ? '0 : wr_ptr_q[p] + 1'b1;
        end
        count_d[p] = count_q[p] + CNT_W'(enq_acc[p]) - CNT_W'(deq_hs[p]);
        if (drop_d[p] && (drop_cnt_q[p] != '1)) begin
          drop_cnt_d[p] = drop_cnt_q[p] + 1'b1;
        end
      end
    end
  end

  // Control state; asynchronous reset empties every queue at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      drop_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      drop_q     <= drop_d;
    end
  end

  // Pointer storage; contents are meaningless outside the occupied window
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (enq_acc[p]) begin
        mem_q[p][wr_ptr_q[p]] <= bus.start_ptrs_i[p];
      end
    end
  end

  // Outputs taken straight from registered state; no input-to-output path
  always_comb begin
    bus.deq_valid_o  = '0;
    bus.deq_ptr_o    = '0;
    bus.full_o       = '0;
    bus.count_o      = count_q;
    bus.drop_o       = drop_q;
    bus.drop_count_o = drop_cnt_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.deq_valid_o[p] = (count_q[p] != '0);
      bus.deq_ptr_o[p]   = mem_q[p][rd_ptr_q[p]];
      bus.full_o[p]      = (count_q[p] == CntFull);
    end
  end
endmodule

// File: tb/tb_egress_ptr_queue.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model.
module tb_egress_ptr_queue;
  localparam int unsigned NP    = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DCW   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  egress_ptr_queue_if #(
    .NUM_PORTS(NP), .ADDR_W(AW), .QUEUE_DEPTH(DEPTH), .DROP_CNT_W(DCW)
  ) bus ();

  egress_ptr_queue #(
    .NUM_PORTS(NP), .ADDR_W(AW), .QUEUE_DEPTH(DEPTH), .DROP_CNT_W(DCW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain queues and counters
  logic [AW-1:0] mq [NP][$];
  int            mdrop_cnt [NP];
  bit            mdrop [NP];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      mdrop_cnt[p] = 0;
      mdrop[p] = 1'b0;
    end
  endtask

  task automatic model_apply(input logic [NP-1:0] wr, input logic [NP*AW-1:0] ptrs,
                             input logic [NP-1:0] fl, input logic [NP-1:0] rdy);
    for (int p = 0; p < NP; p++) begin
      bit hs;
      bit was_full;
      mdrop[p] = 1'b0;
      if (fl[p]) begin
        mq[p].delete();
      end else begin
        hs = (mq[p].size() != 0) && rdy[p];
        was_full = (mq[p].size() == DEPTH);
        if (hs) void'(mq[p].pop_front());
        if (wr[p]) begin
          if (!was_full || hs) begin
            mq[p].push_back(ptrs[p*AW +: AW]);
          end else begin
            mdrop[p] = 1'b1;
            if (mdrop_cnt[p] != 65535) mdrop_cnt[p]++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NP; p++) begin
      check_eq($sformatf("p%0d valid", p), 32'(bus.deq_valid_o[p]), 32'(mq[p].size() != 0));
      if (mq[p].size() != 0)
        check_eq($sformatf("p%0d ptr", p), 32'(bus.deq_ptr_o[p]), 32'(mq[p][0]));
      check_eq($sformatf("p%0d full", p), 32'(bus.full_o[p]), 32'(mq[p].size() == DEPTH));
      check_eq($sformatf("p%0d count", p), 32'(bus.count_o[p]), 32'(mq[p].size()));
      check_eq($sformatf("p%0d drop", p), 32'(bus.drop_o[p]), 32'(mdrop[p]));
      check_eq($sformatf("p%0d drop_count", p), 32'(bus.drop_count_o[p]),
               32'(mdrop_cnt[p]));
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, compare everything
  task automatic step(input logic [NP-1:0] wr, input logic [NP*AW-1:0] ptrs,
                      input logic [NP-1:0] fl, input logic [NP-1:0] rdy);
    bus.write_reqs_i = wr;
    bus.start_ptrs_i = ptrs;
    bus.flush_i      = fl;
    bus.deq_ready_i  = rdy;
    @(posedge clk);
    model_apply(wr, ptrs, fl, rdy);
    #1;
    check_all();
    bus.write_reqs_i = '0;
    bus.flush_i      = '0;
    bus.deq_ready_i  = '0;
  endtask

  function automatic logic [NP*AW-1:0] on_port(input int p, input logic [AW-1:0] v);
    logic [NP*AW-1:0] r;
    r = '0;
    r[p*AW +: AW] = v;
    return r;
  endfunction

  initial begin
    logic [AW-1:0] exp_seq [$];
    bus.write_reqs_i = '0;
    bus.start_ptrs_i = '0;
    bus.flush_i      = '0;
    bus.deq_ready_i  = '0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ordered pass-through on port 1
    step(4'b0010, on_port(1, 8'h10), '0, '0);
    step(4'b0010, on_port(1, 8'h20), '0, '0);
    step(4'b0010, on_port(1, 8'h30), '0, '0);
    check_eq("pt count1", 32'(bus.count_o[1]), 32'd3);
    check_eq("pt count0", 32'(bus.count_o[0]), 32'd0);
    exp_seq = '{8'h10, 8'h20, 8'h30};
    foreach (exp_seq[i]) begin
      check_eq("pt head", 32'(bus.deq_ptr_o[1]), 32'(exp_seq[i]));
      step('0, '0, '0, 4'b0010);
    end
    check_eq("pt empty", 32'(bus.deq_valid_o[1]), 32'd0);

    // Full and drop on port 2
    for (int i = 0; i < 5; i++) begin
      step(4'b0100, on_port(2, 8'hA0 + 8'(i)), '0, '0);
      if (i == 3) check_eq("fd full", 32'(bus.full_o[2]), 32'd1);
    end
    check_eq("fd drop", 32'(bus.drop_o[2]), 32'd1);
    check_eq("fd drop_count", 32'(bus.drop_count_o[2]), 32'd1);
    step('0, '0, '0, '0);
    check_eq("fd drop pulse", 32'(bus.drop_o[2]), 32'd0);

    // Full with same-cycle dequeue: accepted, no drop
    step(4'b0100, on_port(2, 8'hB0), '0, 4'b0100);
    check_eq("fdq drop", 32'(bus.drop_o[2]), 32'd0);
    check_eq("fdq count", 32'(bus.count_o[2]), 32'd4);
    exp_seq = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
    foreach (exp_seq[i]) begin
      check_eq("fdq head", 32'(bus.deq_ptr_o[2]), 32'(exp_seq[i]));
      step('0, '0, '0, 4'b0100);
    end
    check_eq("fdq empty", 32'(bus.deq_valid_o[2]), 32'd0);

    // Wrap-around on port 0
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, on_port(0, 8'(i)), '0, '0);
      check_eq("wrap head", 32'(bus.deq_ptr_o[0]), 32'(i));
      step('0, '0, '0, 4'b0001);
    end
    check_eq("wrap empty", 32'(bus.deq_valid_o[0]), 32'd0);

    // Broadcast then flush port 2 alongside a write to it
    step(4'b1111, {4{8'h55}}, '0, '0);
    step(4'b0100, on_port(2, 8'h66), 4'b0100, '0);
    check_eq("bf count2", 32'(bus.count_o[2]), 32'd0);
    check_eq("bf drop2", 32'(bus.drop_o[2]), 32'd0);
    check_eq("bf count3", 32'(bus.count_o[3]), 32'd1);
    check_eq("bf ptr0", 32'(bus.deq_ptr_o[0]), 32'h55);
    step('0, '0, 4'b1111, '0);

    // Reset mid-operation: port 3 holds 3 entries with two drops recorded
    for (int i = 0; i < 6; i++) step(4'b1000, on_port(3, 8'hC0 + 8'(i)), '0, '0);
    step('0, '0, '0, 4'b1000);
    check_eq("rst pre count", 32'(bus.count_o[3]), 32'd3);
    check_eq("rst pre drops", 32'(bus.drop_count_o[3]), 32'd2);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    check_eq("rst valid3", 32'(bus.deq_valid_o[3]), 32'd0);
    check_eq("rst drops3", 32'(bus.drop_count_o[3]), 32'd0);
    rst_n = 1'b1;
    #1;
    step(4'b1000, on_port(3, 8'h7E), '0, '0);
    check_eq("rst post valid", 32'(bus.deq_valid_o[3]), 32'd1);
    check_eq("rst post ptr", 32'(bus.deq_ptr_o[3]), 32'h7E);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [NP-1:0] wr, fl, rdy;
      logic [NP*AW-1:0] ptrs;
      wr   = NP'($urandom);
      rdy  = NP'($urandom) & NP'($urandom);
      ptrs = (NP*AW)'($urandom);
      fl   = '0;
      for (int p = 0; p < NP; p++) fl[p] = ($urandom_range(0, 19) == 0);
      step(wr, ptrs, fl, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
